// File: rtl/clk_meas_pkg.sv
// Clock measurement sweep scheduler: shared types and constants.
// State encoding and fixed timing for the sweep FSM.
package clk_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CLEAR,
    ST_GATE,
    ST_WAIT_ACK,
    ST_STORE,
    ST_NEXT
  } state_e;

  localparam int CLEAR_CYCLES = 4;
  localparam int ACK_TIMEOUT  = 1024;
  localparam int ACK_W        = $clog2(ACK_TIMEOUT);

endpackage

// File: rtl/clk_meas_next_sel.sv
// Next-channel search: lowest set mask bit, or lowest set bit above idx.
// Purely combinational.
module clk_meas_next_sel #(
  parameter int NR_CLKS = 8,
  localparam int IW = (NR_CLKS > 1) ? $clog2(NR_CLKS) : 1
) (
  input  logic [NR_CLKS-1:0] mask_i,
  input  logic [IW-1:0]      idx_i,
  input  logic               first_i,
  output logic [IW-1:0]      nxt_o,
  output logic               valid_o
);

  // Scan high to low so the lowest qualifying bit is written last.
  always_comb begin
    nxt_o   = '0;
    valid_o = 1'b0;
    for (int i = NR_CLKS - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || i > int'(idx_i))) begin
        nxt_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_meas_sched.sv
// Clock measurement sweep scheduler top.
// Walks the channel mask: select, clear, gate, wait ack, store result.
module clk_meas_sched
  import clk_meas_pkg::*;
#(
  parameter int NR_CLKS = 8,
  parameter int CNT_W   = 32,
  localparam int IW = (NR_CLKS > 1) ? $clog2(NR_CLKS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  input  logic [NR_CLKS-1:0] chan_mask,
  input  logic [CNT_W-1:0]   gate_cycles,
  output logic [IW-1:0]      cnt_sel,
  output logic               cnt_clear,
  output logic               cnt_gate,
  input  logic               cnt_ack,
  input  logic [CNT_W-1:0]   cnt_value,
  output logic               res_wr,
  output logic [IW-1:0]      res_idx,
  output logic [CNT_W-1:0]   res_value,
  output logic               res_timeout,
  output logic               busy,
  output logic               done,
  output logic [15:0]        sweep_cnt
);

  state_e             state_q;
  logic [NR_CLKS-1:0] mask_q;
  logic [CNT_W-1:0]   gate_q;
  logic [CNT_W-1:0]   tmr_q;
  logic [ACK_W-1:0]   ack_q;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      cnt_sel_q;
  logic               cnt_clear_q;
  logic               cnt_gate_q;
  logic               res_wr_q;
  logic [IW-1:0]      res_idx_q;
  logic [CNT_W-1:0]   res_value_q;
  logic               res_timeout_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        sweep_cnt_q;

  logic [IW-1:0]      first_idx;
  logic               first_vld;
  logic [IW-1:0]      next_idx;
  logic               next_vld;
  logic               go;
  logic [CNT_W-1:0]   gate_eff;

  // A zero gate length still opens the window for one cycle.
  assign gate_eff = (gate_cycles == '0) ? CNT_W'(1) : gate_cycles;
  assign go       = (start | continuous) & ~abort;

  clk_meas_next_sel #(.NR_CLKS(NR_CLKS)) u_first (
    .mask_i  (chan_mask),
    .idx_i   ('0),
    .first_i (1'b1),
    .nxt_o   (first_idx),
    .valid_o (first_vld)
  );

  clk_meas_next_sel #(.NR_CLKS(NR_CLKS)) u_next (
    .mask_i  (mask_q),
    .idx_i   (idx_q),
    .first_i (1'b0),
    .nxt_o   (next_idx),
    .valid_o (next_vld)
  );

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      gate_q        <= '0;
      tmr_q         <= '0;
      ack_q         <= '0;
      idx_q         <= '0;
      cnt_sel_q     <= '0;
      cnt_clear_q   <= 1'b0;
      cnt_gate_q    <= 1'b0;
      res_wr_q      <= 1'b0;
      res_idx_q     <= '0;
      res_value_q   <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sweep_cnt_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      res_wr_q <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q     <= ST_IDLE;
        cnt_clear_q <= 1'b0;
        cnt_gate_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (go) begin
              mask_q <= chan_mask;
              gate_q <= gate_eff;
              if (first_vld) begin
                state_q   <= ST_SELECT;
                idx_q     <= first_idx;
                cnt_sel_q <= first_idx;
                busy_q    <= 1'b1;
              end else if (!done_q) begin
                // Empty sweep: report completion, never go busy.
                done_q <= 1'b1;
              end
            end
          end
          ST_SELECT: begin
            state_q     <= ST_CLEAR;
            cnt_clear_q <= 1'b1;
            tmr_q       <= '0;
          end
          ST_CLEAR: begin
            if (tmr_q == CNT_W'(CLEAR_CYCLES - 1)) begin
              state_q     <= ST_GATE;
              cnt_clear_q <= 1'b0;
              cnt_gate_q  <= 1'b1;
              tmr_q       <= '0;
            end else begin
              tmr_q <= tmr_q + CNT_W'(1);
            end
          end
          ST_GATE: begin
            if (tmr_q == gate_q - CNT_W'(1)) begin
              state_q    <= ST_WAIT_ACK;
              cnt_gate_q <= 1'b0;
              ack_q      <= '0;
            end else begin
              tmr_q <= tmr_q + CNT_W'(1);
            end
          end
          ST_WAIT_ACK: begin
            if (cnt_ack) begin
              state_q       <= ST_STORE;
              res_wr_q      <= 1'b1;
              res_idx_q     <= idx_q;
              res_value_q   <= cnt_value;
              res_timeout_q <= 1'b0;
            end else if (ack_q == ACK_W'(ACK_TIMEOUT - 1)) begin
              state_q       <= ST_STORE;
              res_wr_q      <= 1'b1;
              res_idx_q     <= idx_q;
              res_value_q   <= '0;
              res_timeout_q <= 1'b1;
            end else begin
              ack_q <= ack_q + ACK_W'(1);
            end
          end
          ST_STORE: begin
            state_q <= ST_NEXT;
          end
          ST_NEXT: begin
            if (next_vld) begin
              state_q   <= ST_SELECT;
              idx_q     <= next_idx;
              cnt_sel_q <= next_idx;
            end else begin
              done_q      <= 1'b1;
              sweep_cnt_q <= sweep_cnt_q + 16'd1;
              if (continuous && first_vld) begin
                mask_q    <= chan_mask;
                gate_q    <= gate_eff;
                state_q   <= ST_SELECT;
                idx_q     <= first_idx;
                cnt_sel_q <= first_idx;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cnt_sel     = cnt_sel_q;
  assign cnt_clear   = cnt_clear_q;
  assign cnt_gate    = cnt_gate_q;
  assign res_wr      = res_wr_q;
  assign res_idx     = res_idx_q;
  assign res_value   = res_value_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sweep_cnt   = sweep_cnt_q;

endmodule

// File: tb/tb_clk_meas_sched.sv
// Bench for clk_meas_sched: directed sweeps, counter datapath model,
// result scoreboard.
module tb_clk_meas_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  chan_mask = '0;
  logic [31:0] gate_cycles = '0;
  logic [2:0]  cnt_sel;
  logic        cnt_clear;
  logic        cnt_gate;
  logic        cnt_ack = 1'b0;
  logic [31:0] cnt_value = '0;
  logic        res_wr;
  logic [2:0]  res_idx;
  logic [31:0] res_value;
  logic        res_timeout;
  logic        busy;
  logic        done;
  logic [15:0] sweep_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_wr = 0;
  int exp_gate = 0;
  int ack_cd = 0;
  int gate_run = 0;
  int clr_run = 0;
  bit ack_en = 1'b1;
  bit chk_len = 1'b1;
  bit busy_seen = 1'b0;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] val;
    logic        to;
  } exp_t;

  exp_t sb[$];

  clk_meas_sched #(.NR_CLKS(8), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .abort       (abort),
    .chan_mask   (chan_mask),
    .gate_cycles (gate_cycles),
    .cnt_sel     (cnt_sel),
    .cnt_clear   (cnt_clear),
    .cnt_gate    (cnt_gate),
    .cnt_ack     (cnt_ack),
    .cnt_value   (cnt_value),
    .res_wr      (res_wr),
    .res_idx     (res_idx),
    .res_value   (res_value),
    .res_timeout (res_timeout),
    .busy        (busy),
    .done        (done),
    .sweep_cnt   (sweep_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fval(input logic [2:0] i);
    return 32'h1000 + 32'(i) * 32'd17;
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] i, input logic [31:0] v,
                      input logic t);
    exp_t e;
    e.idx = i;
    e.val = v;
    e.to  = t;
    sb.push_back(e);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_sel"}, 32'(cnt_sel), 0);
    chk({nm, "_clr"}, 32'(cnt_clear), 0);
    chk({nm, "_gate"}, 32'(cnt_gate), 0);
    chk({nm, "_wr"}, 32'(res_wr), 0);
    chk({nm, "_ridx"}, 32'(res_idx), 0);
    chk({nm, "_rval"}, res_value, 0);
    chk({nm, "_rto"}, 32'(res_timeout), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_swp"}, 32'(sweep_cnt), 0);
  endtask

  task automatic wait_done(input int target, input int bound,
                           input string nm);
    int k = 0;
    while (n_done < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(n_done >= target), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor, scoreboard checker and counter datapath model.
  always @(negedge clk) begin
    exp_t e;
    if (cnt_ack) cnt_ack = 1'b0;
    if (busy) busy_seen = 1'b1;
    if (done) n_done++;
    if (cnt_clear && cnt_gate) chk("clr_gate_both", 1, 0);
    if (res_wr) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(res_idx), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("res_idx", 32'(res_idx), 32'(e.idx));
        chk("res_value", res_value, e.val);
        chk("res_to", 32'(res_timeout), 32'(e.to));
      end
    end
    if (cnt_gate) begin
      gate_run++;
    end else if (gate_run != 0) begin
      if (chk_len) chk("gate_len", gate_run, exp_gate);
      if (ack_en) ack_cd = 3;
      gate_run = 0;
    end else if (ack_cd != 0) begin
      ack_cd--;
      if (ack_cd == 0) begin
        cnt_ack   = 1'b1;
        cnt_value = fval(cnt_sel);
      end
    end
    if (cnt_clear) begin
      clr_run++;
    end else if (clr_run != 0) begin
      if (chk_len) chk("clr_len", clr_run, 4);
      clr_run = 0;
    end
  end

  initial begin
    int bd;
    int bw;
    int k;
    logic [15:0] bs;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);

    // Two-channel sweep, inputs changed and start pulsed mid-sweep.
    exp_gate = 100;
    chan_mask = 8'h05;
    gate_cycles = 100;
    push(3'd0, fval(3'd0), 1'b0);
    push(3'd2, fval(3'd2), 1'b0);
    bd = n_done;
    bw = n_wr;
    pulse_start();
    chk("busy_run", 32'(busy), 1);
    chan_mask = 8'hFF;
    gate_cycles = 7;
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done(bd + 1, 3000, "t1_done_to");
    repeat (60) @(negedge clk);
    chk("t1_ndone", n_done - bd, 1);
    chk("t1_nwr", n_wr - bw, 2);
    chk("t1_swp", 32'(sweep_cnt), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_sb", sb.size(), 0);

    // Channel 7, datapath never acks.
    ack_en = 1'b0;
    exp_gate = 20;
    chan_mask = 8'h80;
    gate_cycles = 20;
    push(3'd7, 32'd0, 1'b1);
    bd = n_done;
    bw = n_wr;
    pulse_start();
    wait_done(bd + 1, 3000, "t2_done_to");
    repeat (10) @(negedge clk);
    chk("t2_nwr", n_wr - bw, 1);
    chk("t2_swp", 32'(sweep_cnt), 2);
    chk("t2_sb", sb.size(), 0);
    ack_en = 1'b1;

    // Empty mask.
    chan_mask = 8'h00;
    busy_seen = 1'b0;
    bd = n_done;
    bw = n_wr;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t3_ndone", n_done - bd, 1);
    chk("t3_nwr", n_wr - bw, 0);
    chk("t3_busy", 32'(busy_seen), 0);
    chk("t3_swp", 32'(sweep_cnt), 2);

    // Abort and start together while idle.
    chan_mask = 8'h01;
    busy_seen = 1'b0;
    bd = n_done;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_busy", 32'(busy_seen), 0);
    chk("t4_ndone", n_done - bd, 0);

    // Zero gate length.
    exp_gate = 1;
    gate_cycles = 0;
    push(3'd0, fval(3'd0), 1'b0);
    bd = n_done;
    bw = n_wr;
    pulse_start();
    wait_done(bd + 1, 2000, "t5_done_to");
    repeat (10) @(negedge clk);
    chk("t5_nwr", n_wr - bw, 1);
    chk("t5_swp", 32'(sweep_cnt), 3);

    // Continuous sweeps, dropped during the fourth.
    exp_gate = 10;
    chan_mask = 8'h03;
    gate_cycles = 10;
    for (int s = 0; s < 4; s++) begin
      push(3'd0, fval(3'd0), 1'b0);
      push(3'd1, fval(3'd1), 1'b0);
    end
    bd = n_done;
    bw = n_wr;
    bs = sweep_cnt;
    continuous = 1'b1;
    k = 0;
    while (n_wr < bw + 7 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reach", 32'(n_wr >= bw + 7), 1);
    continuous = 1'b0;
    wait_done(bd + 4, 2000, "t6_done_to");
    repeat (60) @(negedge clk);
    chk("t6_ndone", n_done - bd, 4);
    chk("t6_nwr", n_wr - bw, 8);
    chk("t6_swp", 32'(sweep_cnt), 32'(bs + 16'd4));
    chk("t6_busy", 32'(busy), 0);
    chk("t6_sb", sb.size(), 0);

    // Abort during the gate of channel 1.
    exp_gate = 100;
    gate_cycles = 100;
    push(3'd0, fval(3'd0), 1'b0);
    bd = n_done;
    bw = n_wr;
    bs = sweep_cnt;
    pulse_start();
    k = 0;
    while (!(cnt_gate && cnt_sel == 3'd1) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t7_reach", 32'(cnt_gate && cnt_sel == 3'd1), 1);
    chk_len = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t7_gate", 32'(cnt_gate), 0);
    chk("t7_clr", 32'(cnt_clear), 0);
    chk("t7_busy", 32'(busy), 0);
    repeat (1200) @(negedge clk);
    chk("t7_nwr", n_wr - bw, 1);
    chk("t7_ndone", n_done - bd, 0);
    chk("t7_swp", 32'(sweep_cnt), 32'(bs));
    chk("t7_sb", sb.size(), 0);
    chk_len = 1'b1;

    // Reset during clear.
    chan_mask = 8'h01;
    gate_cycles = 5;
    bd = n_done;
    bw = n_wr;
    pulse_start();
    k = 0;
    while (!cnt_clear && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t8_reach", 32'(cnt_clear), 1);
    chk_len = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_reset("t8");
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t8_nwr", n_wr - bw, 0);
    chk("t8_ndone", n_done - bd, 0);
    chk_len = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_meas_sched.md
CLK_MEAS_SCHED -- requirements
Module: clk_meas_sched

Interface
REQ-001 SHALL have parameter NR_CLKS, default 8, number of measurable clock inputs on the counter datapath.
REQ-002 SHALL have parameter CNT_W, default 32, width of gate length and count value.
REQ-003 SHALL have ports: clk  in  1  sole clock (125 MHz system clock); all logic on rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: start  in  1  one-cycle pulse, begin one sweep.
REQ-006 SHALL have ports: continuous  in  1  level; restart sweeps back-to-back while high.
REQ-007 SHALL have ports: abort  in  1  one-cycle pulse, cancel sweep.
REQ-008 SHALL have ports: chan_mask  in  NR_CLKS  channels to measure; sampled at sweep start.
REQ-009 SHALL have ports: gate_cycles  in  CNT_W  gate window length in clk cycles; sampled at sweep start.
REQ-010 SHALL have ports: cnt_sel  out  $clog2(NR_CLKS)  channel select to counter datapath.
REQ-011 SHALL have ports: cnt_clear  out  1  counter clear; cnt_gate  out  1  counter enable window.
REQ-012 SHALL have ports: cnt_ack  in  1  datapath count frozen and valid; cnt_value  in  CNT_W  measured count.
REQ-013 SHALL have ports: res_wr  out  1  result strobe; res_idx  out  $clog2(NR_CLKS); res_value  out  CNT_W; res_timeout  out  1.
REQ-014 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse at sweep end; sweep_cnt  out  16  completed sweeps.

Function
REQ-015 SHALL implement FSM IDLE, SELECT, CLEAR, GATE, WAIT_ACK, STORE, NEXT.
REQ-016 IDLE: on start or continuous, latch chan_mask and gate_cycles (0 treated as 1); mask nonzero -> SELECT with idx = lowest set bit; mask zero -> done pulse next cycle, stay IDLE, no res_wr.
REQ-017 SELECT: drive cnt_sel=idx for 1 cycle -> CLEAR; cnt_sel SHALL hold stable from SELECT through STORE.
REQ-018 CLEAR: cnt_clear=1 for exactly CLEAR_CYCLES (4) cycles -> GATE.
REQ-019 GATE: cnt_gate=1 for exactly latched gate_cycles cycles -> WAIT_ACK; cnt_clear and cnt_gate never both high.
REQ-020 WAIT_ACK: cnt_ack high -> STORE with value captured; no ack within ACK_TIMEOUT (1024) cycles -> STORE with timeout flag.
REQ-021 STORE: res_wr=1 one cycle, res_idx=idx, res_value=cnt_value (0 on timeout), res_timeout=flag -> NEXT.
REQ-022 NEXT: next set bit above idx exists -> SELECT with that idx; else done=1 one cycle, sweep_cnt+1 (wraps 0xFFFF->0), then continuous=1 -> new sweep (resample inputs) else IDLE.
REQ-023 start while busy SHALL be ignored; chan_mask/gate_cycles changes mid-sweep SHALL have no effect.
REQ-024 continuous deasserted mid-sweep: current sweep completes, then IDLE.
REQ-025 abort in any non-IDLE state: next cycle IDLE, cnt_clear=cnt_gate=0, no res_wr, no done, sweep_cnt unchanged; abort beats start in same cycle.
REQ-026 busy SHALL be 1 in every state except IDLE; all outputs registered.

Reset
REQ-027 reset SHALL force IDLE; cnt_sel=0, cnt_clear=0, cnt_gate=0, res_wr=0, res_idx=0, res_value=0, res_timeout=0, busy=0, done=0, sweep_cnt=0.
REQ-028 reset mid-GATE SHALL drop cnt_gate on the next cycle and discard the in-flight measurement.

Structure
REQ-029 Package clk_meas_pkg SHALL hold the state enum, CLEAR_CYCLES=4, ACK_TIMEOUT=1024.
REQ-030 Next-channel search SHALL be sub-module clk_meas_next_sel (mask, current idx, first flag -> next idx, valid), combinational.

Verification
REQ-031 mask=0x05, gate=100, ack 3 cycles after gate end -> res_wr idx0 then idx2, cnt_gate high exactly 100 cycles each, done once, sweep_cnt=1.
REQ-032 mask=0x80, ack never -> after 1024-cycle wait res_wr idx7, res_value=0, res_timeout=1, done pulse.
REQ-033 mask=0x00, start -> done pulse, zero res_wr, busy stays 0 except transiently never.
REQ-034 continuous=1, mask=0x03, gate=10 for 3 sweeps then drop mid-sweep -> sweep completes, sweep_cnt=4, IDLE.
REQ-035 abort during GATE of idx1 (mask=0x03) -> cnt_gate 0 next cycle, no res_wr for idx1, no done; reset mid-CLEAR -> all outputs at reset values.
REQ-036 gate_cycles=0 -> cnt_gate high exactly 1 cycle; start pulsed while busy -> no second sweep.
